// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package imem_loader_pkg;

  // Loader sequencing states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  // Codes reported on the error output
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs four accepted bytes into one little-endian 32-bit word.
module loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [1:0]  idx_reg;
  logic [23:0] shift_reg;

  // The newest byte lands on top, so the first byte of a word ends up in bits [7:0]
  assign word       = {byte_in, shift_reg};
  assign word_ready = byte_valid && (idx_reg == 2'd3);

  // Byte index and partial-word shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg   <= 2'd0;
      shift_reg <= 24'd0;
    end else if (clear) begin
      idx_reg   <= 2'd0;
      shift_reg <= 24'd0;
    end else if (byte_valid) begin
      idx_reg   <= idx_reg + 2'd1;
      shift_reg <= word[31:8];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte frame, writes
// the packed words to IMEM from address 0 and releases the CPU once verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t           state_reg, state_next;
  logic [1:0]       error_next;
  logic [7:0]       len_lo_reg;
  logic [15:0]      len_reg;
  logic [7:0]       csum_reg;
  logic [TMR_W-1:0] timer_reg;

  logic        accept, load_start, timer_expire, data_byte, last_word;
  logic        word_ready;
  logic [31:0] packed_word;
  logic [16:0] len_rx;

  assign accept     = rx_valid && rx_ready;
  assign load_start = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
  assign data_byte  = accept && (state_reg == DATA);
  // Expires on the cycle the idle count would reach TIMEOUT; an accepted byte always wins
  assign timer_expire = rx_ready && !accept && ((int'(timer_reg) + 1) == TIMEOUT);
  // Full frame length as it arrives with the high byte
  assign len_rx    = {1'b0, rx_data, len_lo_reg};
  // The final word's 4th byte moves straight to CSUM so the strobe cycle can already take the checksum byte
  assign last_word = word_ready && ((int'(words_loaded) + 1) == int'(len_reg));

  loader_word_packer u_packer (
    .clk        (clk_in),
    .rst_n      (reset),
    .clear      (load_start),
    .byte_valid (data_byte),
    .byte_in    (rx_data),
    .word_ready (word_ready),
    .word       (packed_word)
  );

  // State register
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and error-code selection
  always_comb begin
    state_next = state_reg;
    error_next = error;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next = LEN0;
          error_next = ERR_NONE;
        end
      end
      LEN0: begin
        if (accept) begin
          state_next = LEN1;
        end else if (timer_expire) begin
          state_next = ERR;
          error_next = ERR_TIMEOUT;
        end
      end
      LEN1: begin
        if (accept) begin
          if (int'(len_rx) > (1 << ADDR_W)) begin
            state_next = ERR;
            error_next = ERR_LEN;
          end else if (len_rx == 17'd0) begin
            state_next = CSUM;
          end else begin
            state_next = DATA;
          end
        end else if (timer_expire) begin
          state_next = ERR;
          error_next = ERR_TIMEOUT;
        end
      end
      DATA: begin
        if (last_word) begin
          state_next = CSUM;
        end else if (timer_expire) begin
          state_next = ERR;
          error_next = ERR_TIMEOUT;
        end
      end
      CSUM: begin
        if (accept) begin
          if (rx_data == csum_reg) begin
            state_next = DONE;
          end else begin
            state_next = ERR;
            error_next = ERR_CSUM;
          end
        end else if (timer_expire) begin
          state_next = ERR;
          error_next = ERR_TIMEOUT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    cpu_rst  = 1'b1;
    case (state_reg)
      LEN0, LEN1, DATA, CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath: length capture, checksum, IMEM write port, word count and idle timer
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      im_we        <= 1'b0;
      im_waddr     <= '0;
      im_wdata     <= 32'd0;
      error        <= ERR_NONE;
      words_loaded <= '0;
      len_lo_reg   <= 8'd0;
      len_reg      <= 16'd0;
      csum_reg     <= 8'd0;
      timer_reg    <= '0;
    end else begin
      im_we <= word_ready;
      error <= error_next;
      if (load_start) begin
        words_loaded <= '0;
        csum_reg     <= 8'd0;
        len_reg      <= 16'd0;
      end
      if (accept && (state_reg == LEN0)) len_lo_reg <= rx_data;
      if (accept && (state_reg == LEN1)) len_reg    <= {rx_data, len_lo_reg};
      if (data_byte) csum_reg <= csum_reg ^ rx_data;
      if (word_ready) begin
        im_waddr     <= words_loaded[ADDR_W-1:0];
        im_wdata     <= packed_word;
        words_loaded <= words_loaded + (ADDR_W+1)'(1);
      end
      if (load_start || accept || !rx_ready) timer_reg <= '0;
      else                                   timer_reg <= timer_reg + TMR_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-level reference model.
module tb_imem_loader;

  localparam int ADDR_W  = 11;
  localparam int TIMEOUT = 40;

  logic              clk_in = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic [1:0]        error;
  logic [ADDR_W:0]   words_loaded;

  always #5 clk_in = ~clk_in;

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .im_we        (im_we),
    .im_waddr     (im_waddr),
    .im_wdata     (im_wdata),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]        frame_q[$];
  logic [7:0]        part_q[$];
  logic [31:0]       exp_wdata[$];
  int                exp_err, exp_words, exp_acc;
  logic [ADDR_W-1:0] got_waddr[$];
  logic [31:0]       got_wdata[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Capture every IMEM write strobe
  always @(negedge clk_in) begin
    if (reset && im_we) begin
      got_waddr.push_back(im_waddr);
      got_wdata.push_back(im_wdata);
    end
  end

  // Reference model: derive writes and outcome straight from the frame bytes
  task automatic build_model();
    int n;
    logic [7:0] cs;
    exp_wdata.delete();
    n = int'(frame_q[0]) + 256 * int'(frame_q[1]);
    if (n > (1 << ADDR_W)) begin
      exp_err = 2; exp_words = 0; exp_acc = 2;
      return;
    end
    cs = 8'd0;
    for (int w = 0; w < n; w++) begin
      logic [31:0] v;
      v = 32'd0;
      for (int b = 0; b < 4; b++) begin
        v  = v + (32'(frame_q[2 + 4*w + b]) << (8*b));
        cs = cs ^ frame_q[2 + 4*w + b];
      end
      exp_wdata.push_back(v);
    end
    exp_err   = (frame_q[2 + 4*n] == cs) ? 0 : 1;
    exp_words = n;
    exp_acc   = 3 + 4*n;
  endtask

  task automatic make_frame(input int n, input bit bad_cs);
    logic [7:0] cs, b;
    logic [15:0] n16;
    n16 = n[15:0];
    cs = 8'd0;
    frame_q.delete();
    frame_q.push_back(n16[7:0]);
    frame_q.push_back(n16[15:8]);
    if (n <= (1 << ADDR_W)) begin
      for (int i = 0; i < 4*n; i++) begin
        b = 8'($urandom_range(255));
        frame_q.push_back(b);
        cs = cs ^ b;
      end
      frame_q.push_back(bad_cs ? (cs ^ 8'($urandom_range(255, 1))) : cs);
    end
  endtask

  task automatic take(input int from, input int upto);
    part_q.delete();
    for (int i = from; i < upto && i < frame_q.size(); i++) part_q.push_back(frame_q[i]);
  endtask

  // Pulse start; a load should begin with CPU in reset and status cleared
  task automatic do_start();
    got_waddr.delete();
    got_wdata.delete();
    @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_cpu_rst", cpu_rst, 1);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
    chk("start_words", words_loaded, 0);
  endtask

  // Offer bytes with random gaps; returns after the edge that takes the last one,
  // or stops early once the loader drops rx_ready
  task automatic drive_bytes(input logic [7:0] q[$], input int gap_pct, output int n_acc);
    int i, budget;
    i = 0; budget = 0; n_acc = 0;
    while (i < q.size()) begin
      @(negedge clk_in);
      if (!rx_ready) break;
      if (budget >= 2000) begin
        chk("drive_budget", budget, 0);
        break;
      end
      rx_valid = ($urandom_range(99) >= gap_pct);
      rx_data  = q[i];
      @(posedge clk_in);
      if (rx_valid) begin
        i++;
        n_acc++;
      end
      budget++;
    end
  endtask

  task automatic check_result(input int n_acc);
    @(negedge clk_in);
    rx_valid = 1'b0;
    chk("accepted", n_acc, exp_acc);
    chk("nwrites", got_wdata.size(), exp_wdata.size());
    for (int i = 0; i < got_wdata.size() && i < exp_wdata.size(); i++) begin
      chk("waddr", got_waddr[i], i);
      chk("wdata", got_wdata[i], exp_wdata[i]);
    end
    chk("done", done, exp_err == 0);
    chk("cpu_rst", cpu_rst, exp_err != 0);
    chk("error", error, exp_err);
    chk("words_loaded", words_loaded, exp_words);
    chk("busy", busy, 0);
    $display("frame N=%0d err=%0d words=%0d writes=%0d", exp_words, error, words_loaded, got_wdata.size());
  endtask

  task automatic run_frame(input int gap_pct);
    int n_acc;
    build_model();
    do_start();
    drive_bytes(frame_q, gap_pct, n_acc);
    check_result(n_acc);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_im_we"}, im_we, 0);
    chk({tag, "_im_waddr"}, im_waddr, 0);
    chk({tag, "_im_wdata"}, im_wdata, 0);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_words"}, words_loaded, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, n_acc2, wl_before;

    // Reset state
    repeat (3) @(negedge clk_in);
    check_reset_values("rst");
    reset = 1'b1;

    // Single-word frame, back-to-back bytes
    frame_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h01, 8'h3C, 8'h2E};
    run_frame(0);
    if (got_wdata.size() > 0) chk("t1_word", got_wdata[0], 32'h3C01_0013);

    // Same frame, bad checksum
    frame_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h01, 8'h3C, 8'h2F};
    run_frame(0);

    // Length one past capacity; following bytes must not be taken
    frame_q = '{8'h01, 8'h08, 8'hAA, 8'hBB};
    run_frame(0);

    // Timeout after the 5th data byte of an N=2 frame
    make_frame(2, 1'b0);
    take(0, 7);
    do_start();
    drive_bytes(part_q, 0, n_acc);
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      @(negedge clk_in);
      rx_valid = 1'b0;
      if (k == TIMEOUT) begin
        chk("tmo_early_error", error, 0);
        chk("tmo_early_busy", busy, 1);
      end
    end
    chk("tmo_error", error, 3);
    chk("tmo_words", words_loaded, 1);
    chk("tmo_cpu_rst", cpu_rst, 1);
    chk("tmo_done", done, 0);
    chk("tmo_writes", got_wdata.size(), 1);
    $display("timeout frame err=%0d words=%0d", error, words_loaded);

    // Asynchronous reset midway through word 1 of an N=3 load
    make_frame(3, 1'b0);
    take(0, 8);
    do_start();
    drive_bytes(part_q, 0, n_acc);
    #3;
    reset = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge clk_in);
    rx_valid = 1'b0;
    reset = 1'b1;
    $display("async reset mid-load checked");
    run_frame(20);

    // Empty frame
    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame(0);

    // start while busy is ignored
    make_frame(2, 1'b0);
    build_model();
    take(0, 9);
    do_start();
    drive_bytes(part_q, 10, n_acc);
    @(negedge clk_in);
    rx_valid = 1'b0;
    wl_before = int'(words_loaded);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    chk("busy_start_busy", busy, 1);
    chk("busy_start_words", words_loaded, wl_before);
    chk("busy_start_error", error, 0);
    take(9, frame_q.size());
    drive_bytes(part_q, 10, n_acc2);
    check_result(n_acc + n_acc2);

    // Randomized frames, restarting from DONE/ERR each time
    for (int it = 0; it < 10; it++) begin
      int n;
      n = ($urandom_range(7) == 0) ? int'($urandom_range(3000, 2049)) : int'($urandom_range(6));
      make_frame(n, $urandom_range(3) == 0);
      run_frame(30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
